// File: rtl/timer_ctrl.sv
// Memory-mapped millisecond timer: counts ticks against COMPARE, raises a level irq.
// Latency: bus access completes one cycle after the strobe; irq follows the registered PEND/IE bits directly.
// Backpressure: none; every access completes in exactly one cycle and is never stalled.
//
// Optional feature macro: TIMER_CTRL_PRESCALE_EN (adds the PRESCALE register and tick divider).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   tick_in    one-cycle pulse per millisecond from ms_counter
//   bus_addr   register word index (0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS, 4 PRESCALE, 5-7 reserved)
//   bus_wdata  write data
//   bus_we     write strobe, one cycle
//   bus_re     read strobe, one cycle
//   bus_rdata  registered read data, valid while bus_ready is high
//   bus_ready  one-cycle access-complete pulse
//   irq        level interrupt, STATUS.PEND & CTRL.IE
module timer_ctrl #(
    parameter int CNT_W  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic [2:0]        bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_we,
    input  logic              bus_re,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ready,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_FIRED   = 2'd2
    } state_t;

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_COUNT    = 3'd1;
    localparam logic [2:0] A_COMPARE  = 3'd2;
    localparam logic [2:0] A_STATUS   = 3'd3;
    localparam logic [2:0] A_PRESCALE = 3'd4;

    state_t              state_q,   state_d;
    logic                en_q,      en_d;
    logic                mode_q,    mode_d;
    logic                ie_q,      ie_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic [CNT_W-1:0]    compare_q, compare_d;
    logic                pend_q,    pend_d;
    logic                ovf_q,     ovf_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic                ready_q,   ready_d;

    logic                wr_ctrl, wr_count, wr_compare, wr_status;
    logic                counted_tick;
    logic                do_count;
    logic                match;
    logic [CNT_W-1:0]    count_inc;
    logic [DATA_W-1:0]   rd_val;

    // Only the low bits of the write bus are decoded for most registers.
    logic                unused_wdata;
    assign unused_wdata = ^bus_wdata;

    assign wr_ctrl    = bus_we && (bus_addr == A_CTRL);
    assign wr_count   = bus_we && (bus_addr == A_COUNT);
    assign wr_compare = bus_we && (bus_addr == A_COMPARE);
    assign wr_status  = bus_we && (bus_addr == A_STATUS);

`ifdef TIMER_CTRL_PRESCALE_EN
    logic [15:0]         prescale_q, prescale_d;
    logic [15:0]         div_q,      div_d;
    logic                wr_prescale;
    logic                start_run;

    assign wr_prescale = bus_we && (bus_addr == A_PRESCALE);
    // Any entry into RUNNING restarts the divider so the first period is full length.
    assign start_run   = wr_ctrl && bus_wdata[0] && (state_q != ST_RUNNING);
    // Counted tick on the (PRESCALE+1)-th raw tick.
    assign counted_tick = tick_in && (div_q == prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        div_d      = div_q;
        if (tick_in && (state_q == ST_RUNNING)) begin
            div_d = (div_q == prescale_q) ? 16'd0 : div_q + 16'd1;
        end
        if (start_run || wr_prescale) begin
            div_d = 16'd0;
        end
        if (wr_prescale) begin
            prescale_d = bus_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= 16'd0;
            div_q      <= 16'd0;
        end else begin
            prescale_q <= prescale_d;
            div_q      <= div_d;
        end
    end
`else
    assign counted_tick = tick_in;
`endif

    assign do_count  = counted_tick && (state_q == ST_RUNNING);
    assign count_inc = count_q + 1'b1;
    // COMPARE of zero disables matching; the counter then free-runs and wraps.
    assign match     = (compare_q != '0) && (count_inc == compare_q);

    // Read mux sees pre-write register values, so a combined read/write returns old data.
    always_comb begin
        rd_val = '0;
        case (bus_addr)
            A_CTRL:    rd_val[2:0]       = {ie_q, mode_q, en_q};
            A_COUNT:   rd_val[CNT_W-1:0] = count_q;
            A_COMPARE: rd_val[CNT_W-1:0] = compare_q;
            A_STATUS:  rd_val[1:0]       = {ovf_q, pend_q};
`ifdef TIMER_CTRL_PRESCALE_EN
            A_PRESCALE: rd_val[15:0]     = prescale_q;
`endif
            default:   rd_val            = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        mode_d    = mode_q;
        ie_d      = ie_q;
        count_d   = count_q;
        compare_d = compare_q;
        pend_d    = pend_q;
        ovf_d     = ovf_q;
        rdata_d   = bus_re ? rd_val : '0;
        ready_d   = bus_we || bus_re;

        // W1C first so that a hardware set on the same edge takes precedence.
        if (wr_status) begin
            pend_d = pend_q & ~bus_wdata[0];
            ovf_d  = ovf_q  & ~bus_wdata[1];
        end

        // Match is evaluated against the old COMPARE even if COMPARE is written now.
        if (do_count) begin
            if (match) begin
                pend_d = 1'b1;
                if (mode_q) begin
                    count_d = '0;
                end else begin
                    count_d = compare_q;
                    en_d    = 1'b0;
                    state_d = ST_FIRED;
                end
            end else begin
                count_d = count_inc;
                if (count_q == '1) begin
                    ovf_d = 1'b1;
                end
            end
        end

        // Software COUNT write overrides any tick on the same edge.
        if (wr_count) begin
            count_d = bus_wdata[CNT_W-1:0];
        end

        if (wr_compare) begin
            compare_d = bus_wdata[CNT_W-1:0];
        end

        // A CTRL write decides the next state even if a one-shot match lands on the
        // same edge; software intent is honoured over the hardware EN clear.
        if (wr_ctrl) begin
            en_d   = bus_wdata[0];
            mode_d = bus_wdata[1];
            ie_d   = bus_wdata[2];
            if (bus_wdata[0]) begin
                state_d = ST_RUNNING;
                if (state_q == ST_FIRED) begin
                    count_d = '0;
                end
            end else begin
                state_d = ST_STOPPED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_STOPPED;
            en_q      <= 1'b0;
            mode_q    <= 1'b0;
            ie_q      <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            pend_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            ie_q      <= ie_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_ready = ready_q;
    assign irq       = pend_q & ie_q;

endmodule
